// File: rtl/systolic_pe_db.sv
// Double-buffered output-stationary systolic PE: forwards operands east/south, accumulates a
// saturating MAC into the compute bank and unloads the other bank over a west-to-east drain chain.
module systolic_pe_db #(
    parameter int DATA_W     = 16,
    parameter int ACC_W      = 40,
    parameter int SIGNED     = 1,
    parameter int CHAIN_HEAD = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] a_i,
    input  logic              a_valid_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              b_valid_i,
    output logic [DATA_W-1:0] a_o,
    output logic              a_valid_o,
    output logic [DATA_W-1:0] b_o,
    output logic              b_valid_o,
    input  logic              acc_first_i,
    input  logic              swap_i,
    output logic              swap_err_o,
    input  logic              drain_start_i,
    input  logic [ACC_W-1:0]  drain_i,
    input  logic              drain_sat_i,
    input  logic              drain_last_i,
    input  logic              drain_valid_i,
    output logic              drain_ready_o,
    output logic [ACC_W-1:0]  drain_o,
    output logic              drain_sat_o,
    output logic              drain_last_o,
    output logic              drain_valid_o,
    input  logic              drain_ready_i,
    output logic [1:0]        drain_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SELF = 2'd1,
        S_PASS = 2'd2
    } drain_state_e;

    localparam int EXT_W = ACC_W + 1 - 2 * DATA_W;

    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic              a_valid_q, a_valid_d, b_valid_q, b_valid_d;
    logic [ACC_W-1:0]  acc_q [2];
    logic [ACC_W-1:0]  acc_d [2];
    logic [1:0]        sat_q, sat_d, full_q, full_d;
    logic              cb_q, cb_d;
    logic              swap_err_q, swap_err_d;
    drain_state_e      state_q, state_d;
    logic [ACC_W-1:0]  out_q, out_d;
    logic              out_sat_q, out_sat_d, out_last_q, out_last_d, out_valid_q, out_valid_d;

    logic                db;
    logic                drain_ready;
    logic [ACC_W-1:0]    acc_cur;
    logic [2*DATA_W-1:0] a_ext, b_ext, prod;
    logic [ACC_W:0]      prod_ext, acc_ext, base, sum;
    logic                ovf, mac_sat;
    logic [ACC_W-1:0]    mac_val, sat_max, sat_min;

    always_comb begin
        a_d         = a_i;
        a_valid_d   = a_valid_i;
        b_d         = b_i;
        b_valid_d   = b_valid_i;
        acc_d       = acc_q;
        sat_d       = sat_q;
        full_d      = full_q;
        cb_d        = cb_q;
        swap_err_d  = 1'b0;
        state_d     = state_q;
        out_d       = out_q;
        out_sat_d   = out_sat_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        db      = ~cb_q;
        acc_cur = acc_q[cb_q];

        // The low 2*DATA_W bits of the product of extended operands are the exact product.
        a_ext    = (SIGNED != 0) ? {{DATA_W{a_i[DATA_W-1]}}, a_i} : {{DATA_W{1'b0}}, a_i};
        b_ext    = (SIGNED != 0) ? {{DATA_W{b_i[DATA_W-1]}}, b_i} : {{DATA_W{1'b0}}, b_i};
        prod     = a_ext * b_ext;
        prod_ext = (SIGNED != 0) ? {{EXT_W{prod[2*DATA_W-1]}}, prod} : {{EXT_W{1'b0}}, prod};
        acc_ext  = (SIGNED != 0) ? {acc_cur[ACC_W-1], acc_cur} : {1'b0, acc_cur};
        base     = acc_first_i ? {(ACC_W + 1){1'b0}} : acc_ext;
        sum      = base + prod_ext;
        ovf      = (SIGNED != 0) ? (sum[ACC_W] != sum[ACC_W-1]) : sum[ACC_W];
        sat_max  = (SIGNED != 0) ? {1'b0, {(ACC_W - 1){1'b1}}} : {ACC_W{1'b1}};
        sat_min  = {1'b1, {(ACC_W - 1){1'b0}}};
        mac_val  = ovf ? (((SIGNED != 0) && sum[ACC_W]) ? sat_min : sat_max) : sum[ACC_W-1:0];
        mac_sat  = (acc_first_i ? 1'b0 : sat_q[cb_q]) | ovf;

        if (a_valid_i && b_valid_i) begin
            acc_d[cb_q] = mac_val;
            sat_d[cb_q] = mac_sat;
        end

        // Valid/ready: a word moves when valid and ready are both high at the clock edge;
        // the sender holds the word stable until then.
        drain_ready = (state_q == S_PASS) && (!out_valid_q || drain_ready_i);

        case (state_q)
            S_IDLE: begin
                if (drain_start_i && full_q[db]) begin
                    out_d       = acc_q[db];
                    out_sat_d   = sat_q[db];
                    out_last_d  = (CHAIN_HEAD != 0);
                    out_valid_d = 1'b1;
                    state_d     = S_SELF;
                end
            end
            S_SELF: begin
                if (drain_ready_i) begin
                    out_valid_d = 1'b0;
                    full_d[db]  = 1'b0;
                    state_d     = (CHAIN_HEAD != 0) ? S_IDLE : S_PASS;
                end
            end
            S_PASS: begin
                if (out_valid_q && drain_ready_i) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) state_d = S_IDLE;
                end
                if (drain_valid_i && drain_ready) begin
                    out_d       = drain_i;
                    out_sat_d   = drain_sat_i;
                    out_last_d  = drain_last_i;
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A bank still waiting to be drained is never handed back to the MAC.
        if (swap_i) begin
            if (!full_q[db]) begin
                cb_d         = db;
                full_d[cb_q] = 1'b1;
            end else begin
                swap_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q         <= '0;
            a_valid_q   <= 1'b0;
            b_q         <= '0;
            b_valid_q   <= 1'b0;
            acc_q       <= '{default: '0};
            sat_q       <= '0;
            full_q      <= '0;
            cb_q        <= 1'b0;
            swap_err_q  <= 1'b0;
            state_q     <= S_IDLE;
            out_q       <= '0;
            out_sat_q   <= 1'b0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            a_q         <= a_d;
            a_valid_q   <= a_valid_d;
            b_q         <= b_d;
            b_valid_q   <= b_valid_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            full_q      <= full_d;
            cb_q        <= cb_d;
            swap_err_q  <= swap_err_d;
            state_q     <= state_d;
            out_q       <= out_d;
            out_sat_q   <= out_sat_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign a_o           = a_q;
    assign a_valid_o     = a_valid_q;
    assign b_o           = b_q;
    assign b_valid_o     = b_valid_q;
    assign swap_err_o    = swap_err_q;
    assign drain_ready_o = drain_ready;
    assign drain_o       = out_q;
    assign drain_sat_o   = out_sat_q;
    assign drain_last_o  = out_last_q;
    assign drain_valid_o = out_valid_q;
    assign drain_state_o = state_q;

endmodule

// File: tb/tb_systolic_pe_db.sv
// Directed bench for systolic_pe_db: a standalone 32-bit-accumulator head PE and a
// three-PE drain row with default widths.
module tb_systolic_pe_db;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Standalone PE
    logic [15:0] s_a = '0, s_b = '0;
    logic        s_av = 0, s_bv = 0, s_first = 0, s_swap = 0, s_dstart = 0, s_dready = 0;
    logic [15:0] s_ao, s_bo;
    logic        s_avo, s_bvo, s_err, s_rdy_o, s_dsat, s_dlast, s_dvalid;
    logic [31:0] s_dout;
    logic [1:0]  s_state;

    systolic_pe_db #(.DATA_W(16), .ACC_W(32), .SIGNED(1), .CHAIN_HEAD(1)) u_dut (
        .clk(clk), .reset(reset),
        .a_i(s_a), .a_valid_i(s_av), .b_i(s_b), .b_valid_i(s_bv),
        .a_o(s_ao), .a_valid_o(s_avo), .b_o(s_bo), .b_valid_o(s_bvo),
        .acc_first_i(s_first), .swap_i(s_swap), .swap_err_o(s_err),
        .drain_start_i(s_dstart),
        .drain_i(32'd0), .drain_sat_i(1'b0), .drain_last_i(1'b0), .drain_valid_i(1'b0),
        .drain_ready_o(s_rdy_o),
        .drain_o(s_dout), .drain_sat_o(s_dsat), .drain_last_o(s_dlast), .drain_valid_o(s_dvalid),
        .drain_ready_i(s_dready), .drain_state_o(s_state)
    );

    // Three-PE row: index 0 is the head, index 2 is the east end
    logic [15:0] c_a [3];
    logic [15:0] c_b [3];
    logic        c_v = 0, c_first = 0, c_swap = 0, c_dstart = 0, c_ready = 0;
    logic [15:0] c_ao [3];
    logic [15:0] c_bo [3];
    logic        c_avo [3];
    logic        c_bvo [3];
    logic        c_err [3];
    logic        c_rdy_o [3];
    logic [39:0] c_dout [3];
    logic        c_dsat [3];
    logic        c_dlast [3];
    logic        c_dvalid [3];
    logic [1:0]  c_state [3];

    systolic_pe_db #(.CHAIN_HEAD(1)) u_c0 (
        .clk(clk), .reset(reset),
        .a_i(c_a[0]), .a_valid_i(c_v), .b_i(c_b[0]), .b_valid_i(c_v),
        .a_o(c_ao[0]), .a_valid_o(c_avo[0]), .b_o(c_bo[0]), .b_valid_o(c_bvo[0]),
        .acc_first_i(c_first), .swap_i(c_swap), .swap_err_o(c_err[0]),
        .drain_start_i(c_dstart),
        .drain_i(40'd0), .drain_sat_i(1'b0), .drain_last_i(1'b0), .drain_valid_i(1'b0),
        .drain_ready_o(c_rdy_o[0]),
        .drain_o(c_dout[0]), .drain_sat_o(c_dsat[0]), .drain_last_o(c_dlast[0]),
        .drain_valid_o(c_dvalid[0]), .drain_ready_i(c_rdy_o[1]), .drain_state_o(c_state[0])
    );

    systolic_pe_db #(.CHAIN_HEAD(0)) u_c1 (
        .clk(clk), .reset(reset),
        .a_i(c_a[1]), .a_valid_i(c_v), .b_i(c_b[1]), .b_valid_i(c_v),
        .a_o(c_ao[1]), .a_valid_o(c_avo[1]), .b_o(c_bo[1]), .b_valid_o(c_bvo[1]),
        .acc_first_i(c_first), .swap_i(c_swap), .swap_err_o(c_err[1]),
        .drain_start_i(c_dstart),
        .drain_i(c_dout[0]), .drain_sat_i(c_dsat[0]), .drain_last_i(c_dlast[0]),
        .drain_valid_i(c_dvalid[0]), .drain_ready_o(c_rdy_o[1]),
        .drain_o(c_dout[1]), .drain_sat_o(c_dsat[1]), .drain_last_o(c_dlast[1]),
        .drain_valid_o(c_dvalid[1]), .drain_ready_i(c_rdy_o[2]), .drain_state_o(c_state[1])
    );

    systolic_pe_db #(.CHAIN_HEAD(0)) u_c2 (
        .clk(clk), .reset(reset),
        .a_i(c_a[2]), .a_valid_i(c_v), .b_i(c_b[2]), .b_valid_i(c_v),
        .a_o(c_ao[2]), .a_valid_o(c_avo[2]), .b_o(c_bo[2]), .b_valid_o(c_bvo[2]),
        .acc_first_i(c_first), .swap_i(c_swap), .swap_err_o(c_err[2]),
        .drain_start_i(c_dstart),
        .drain_i(c_dout[1]), .drain_sat_i(c_dsat[1]), .drain_last_i(c_dlast[1]),
        .drain_valid_i(c_dvalid[1]), .drain_ready_o(c_rdy_o[2]),
        .drain_o(c_dout[2]), .drain_sat_o(c_dsat[2]), .drain_last_o(c_dlast[2]),
        .drain_valid_o(c_dvalid[2]), .drain_ready_i(c_ready), .drain_state_o(c_state[2])
    );

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mac(input logic [15:0] a, input logic [15:0] b, input logic first);
        s_a = a; s_b = b; s_av = 1'b1; s_bv = 1'b1; s_first = first;
        tick();
        s_av = 1'b0; s_bv = 1'b0; s_first = 1'b0;
    endtask

    task automatic do_swap(output logic err);
        s_swap = 1'b1;
        tick();
        s_swap = 1'b0;
        err = s_err;
    endtask

    task automatic drain_one(output logic valid, output logic [31:0] d,
                             output logic sat, output logic last);
        s_dstart = 1'b1;
        tick();
        s_dstart = 1'b0;
        valid = s_dvalid; d = s_dout; sat = s_dsat; last = s_dlast;
        s_dready = 1'b1;
        tick();
        s_dready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        s_a = 16'h5A5A; s_av = 1'b1;
        tick(); tick();
        s_av = 1'b0; s_a = '0;
        checks++;
        if ({s_ao, s_avo, s_bvo, s_err, s_rdy_o, s_dvalid, s_dout, s_state} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ao=%h avo=%b dvalid=%b dout=%h state=%0d, want all 0",
                     s_ao, s_avo, s_dvalid, s_dout, s_state);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_forward();
        s_a = 16'h1234; s_av = 1'b1; s_b = 16'hABCD; s_bv = 1'b0;
        tick();
        checks++;
        if ({s_ao, s_avo, s_bo, s_bvo} !== {16'h1234, 1'b1, 16'hABCD, 1'b0}) begin
            errors++;
            $display("FAIL forward: got a=%h/%b b=%h/%b, want 1234/1 abcd/0", s_ao, s_avo, s_bo, s_bvo);
        end
        s_av = 1'b0; s_a = '0; s_b = '0;
        tick();
    endtask

    task automatic test_basic_mac();
        logic err, v, sat, last;
        logic [31:0] d;
        mac(16'd3, 16'd4, 1'b1);
        mac(16'hFFFE, 16'd5, 1'b0);
        mac(16'd7, 16'hFFFF, 1'b0);
        do_swap(err);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL basic_swap_err: got %b want 0", err); end
        s_dstart = 1'b1;
        tick();
        s_dstart = 1'b0;
        checks++;
        if ({s_dvalid, s_dout, s_dsat, s_dlast, s_state} !== {1'b1, 32'hFFFF_FFFB, 1'b0, 1'b1, 2'd1}) begin
            errors++;
            $display("FAIL basic_drain: got v=%b d=%h sat=%b last=%b st=%0d, want 1 fffffffb 0 1 1",
                     s_dvalid, s_dout, s_dsat, s_dlast, s_state);
        end
        tick();
        checks++;
        if ({s_dvalid, s_dout} !== {1'b1, 32'hFFFF_FFFB}) begin
            errors++; $display("FAIL basic_hold: got v=%b d=%h, want 1 fffffffb", s_dvalid, s_dout);
        end
        s_dready = 1'b1;
        tick();
        s_dready = 1'b0;
        checks++;
        if ({s_dvalid, s_state} !== {1'b0, 2'd0}) begin
            errors++; $display("FAIL basic_accept: got v=%b st=%0d, want 0 0", s_dvalid, s_state);
        end
        drain_one(v, d, sat, last);
        checks++;
        if (v !== 1'b0) begin errors++; $display("FAIL basic_empty_start: got v=%b want 0", v); end
    endtask

    task automatic test_saturation();
        logic err, v, sat, last;
        logic [31:0] d;
        // positive clamp in bank 1
        mac(16'h7FFF, 16'h7FFF, 1'b1);
        mac(16'h7FFF, 16'h7FFF, 1'b0);
        mac(16'h7FFF, 16'h7FFF, 1'b0);
        do_swap(err);
        drain_one(v, d, sat, last);
        checks++;
        if ({v, d, sat} !== {1'b1, 32'h7FFF_FFFF, 1'b1}) begin
            errors++; $display("FAIL sat_pos: got v=%b d=%h sat=%b, want 1 7fffffff 1", v, d, sat);
        end
        // negative clamp in bank 0
        mac(16'h8000, 16'h7FFF, 1'b1);
        mac(16'h8000, 16'h7FFF, 1'b0);
        mac(16'h8000, 16'h7FFF, 1'b0);
        do_swap(err);
        drain_one(v, d, sat, last);
        checks++;
        if ({v, d, sat} !== {1'b1, 32'h8000_0000, 1'b1}) begin
            errors++; $display("FAIL sat_neg: got v=%b d=%h sat=%b, want 1 80000000 1", v, d, sat);
        end
        // bank 1 again: acc_first clears the stale sat flag
        mac(16'd1, 16'd1, 1'b1);
        do_swap(err);
        drain_one(v, d, sat, last);
        checks++;
        if ({v, d, sat} !== {1'b1, 32'd1, 1'b0}) begin
            errors++; $display("FAIL sat_clear: got v=%b d=%h sat=%b, want 1 00000001 0", v, d, sat);
        end
    endtask

    task automatic test_swap_err();
        logic err, v, sat, last;
        logic [31:0] d;
        mac(16'd5, 16'd5, 1'b1);
        do_swap(err);
        mac(16'd2, 16'd2, 1'b1);
        do_swap(err);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL swap_err_pulse: got %b want 1", err); end
        tick();
        checks++;
        if (s_err !== 1'b0) begin errors++; $display("FAIL swap_err_one_cycle: got %b want 0", s_err); end
        mac(16'd1, 16'd1, 1'b0);
        drain_one(v, d, sat, last);
        checks++;
        if ({v, d} !== {1'b1, 32'd25}) begin
            errors++; $display("FAIL swap_err_drain_bank: got v=%b d=%0d, want 1 25", v, d);
        end
        do_swap(err);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL swap_after_drain: got %b want 0", err); end
        drain_one(v, d, sat, last);
        checks++;
        if ({v, d} !== {1'b1, 32'd5}) begin
            errors++; $display("FAIL swap_err_compute_bank: got v=%b d=%0d, want 1 5", v, d);
        end
    endtask

    task automatic test_back_to_back();
        logic err, v, sat, last;
        logic [31:0] d;
        mac(16'd10, 16'd10, 1'b1);
        mac(16'hFFFD, 16'd4, 1'b0);
        do_swap(err);
        s_dstart = 1'b1;
        mac(16'd1, 16'd2, 1'b1);
        s_dstart = 1'b0;
        mac(16'd3, 16'd4, 1'b0);
        checks++;
        if ({s_dvalid, s_dout} !== {1'b1, 32'd88}) begin
            errors++; $display("FAIL b2b_tile1_word: got v=%b d=%0d, want 1 88", s_dvalid, s_dout);
        end
        s_swap = 1'b1;
        mac(16'd5, 16'd6, 1'b0);
        s_swap = 1'b0;
        checks++;
        if (s_err !== 1'b1) begin errors++; $display("FAIL b2b_swap_during_drain: got %b want 1", s_err); end
        mac(16'hFFF9, 16'd8, 1'b0);
        checks++;
        if ({s_dvalid, s_dout, s_state} !== {1'b1, 32'd88, 2'd1}) begin
            errors++; $display("FAIL b2b_tile1_stable: got v=%b d=%0d st=%0d, want 1 88 1",
                               s_dvalid, s_dout, s_state);
        end
        s_dready = 1'b1;
        tick();
        s_dready = 1'b0;
        do_swap(err);
        drain_one(v, d, sat, last);
        checks++;
        if ({v, d, sat} !== {1'b1, 32'hFFFF_FFF4, 1'b0}) begin
            errors++; $display("FAIL b2b_tile2: got v=%b d=%h sat=%b, want 1 fffffff4 0", v, d, sat);
        end
    endtask

    task automatic test_reset_mid_drain();
        logic err, v, sat, last;
        logic [31:0] d;
        mac(16'd9, 16'd9, 1'b1);
        do_swap(err);
        s_dstart = 1'b1;
        tick();
        s_dstart = 1'b0;
        checks++;
        if ({s_dvalid, s_dout, s_state} !== {1'b1, 32'd81, 2'd1}) begin
            errors++; $display("FAIL rst_pre: got v=%b d=%0d st=%0d, want 1 81 1", s_dvalid, s_dout, s_state);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({s_dvalid, s_dout, s_dsat, s_dlast, s_state, s_err, s_rdy_o, s_avo} !== '0) begin
            errors++; $display("FAIL rst_mid_drain: got v=%b d=%h last=%b st=%0d, want all 0",
                               s_dvalid, s_dout, s_dlast, s_state);
        end
        drain_one(v, d, sat, last);
        checks++;
        if ({v, s_state} !== {1'b0, 2'd0}) begin
            errors++; $display("FAIL rst_start_ignored: got v=%b st=%0d, want 0 0", v, s_state);
        end
    endtask

    task automatic test_chain();
        logic [41:0] exp_q[$];
        logic [41:0] word, hold_word, exp_w;
        logic        prev_hold;
        c_a[0] = 16'd5; c_b[0] = 16'd2;
        c_a[1] = 16'd4; c_b[1] = 16'd5;
        c_a[2] = 16'd6; c_b[2] = 16'd5;
        c_v = 1'b1; c_first = 1'b1;
        tick();
        c_v = 1'b0; c_first = 1'b0;
        c_swap = 1'b1;
        tick();
        c_swap = 1'b0;
        c_dstart = 1'b1;
        tick();
        c_dstart = 1'b0;
        checks++;
        if ({c_dvalid[2], c_dout[2]} !== {1'b1, 40'd30}) begin
            errors++; $display("FAIL chain_first_valid: got v=%b d=%0d, want 1 30", c_dvalid[2], c_dout[2]);
        end
        exp_q.push_back({1'b0, 1'b0, 40'd30});
        exp_q.push_back({1'b0, 1'b0, 40'd20});
        exp_q.push_back({1'b0, 1'b1, 40'd10});
        prev_hold = 1'b0;
        hold_word = '0;
        for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
            c_ready = cyc[0];
            word = {c_dsat[2], c_dlast[2], c_dout[2]};
            if (prev_hold) begin
                checks++;
                if (!c_dvalid[2] || word !== hold_word) begin
                    errors++; $display("FAIL chain_stall_stable: got v=%b w=%h, want 1 %h",
                                       c_dvalid[2], word, hold_word);
                end
            end
            prev_hold = c_dvalid[2] && !c_ready;
            hold_word = word;
            if (c_dvalid[2] && c_ready) begin
                exp_w = exp_q.pop_front();
                checks++;
                if (word !== exp_w) begin
                    errors++; $display("FAIL chain_word: got sat/last/data=%h, want %h", word, exp_w);
                end
            end
            tick();
        end
        c_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL chain_timeout: got %0d words missing, want 0", exp_q.size());
        end
        checks++;
        if ({c_state[0], c_state[1], c_state[2], c_dvalid[2]} !== '0) begin
            errors++; $display("FAIL chain_idle: got st=%0d/%0d/%0d v=%b, want 0/0/0 0",
                               c_state[0], c_state[1], c_state[2], c_dvalid[2]);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            c_a[i] = '0;
            c_b[i] = '0;
        end
        test_reset();
        test_forward();
        test_basic_mac();
        test_saturation();
        test_swap_err();
        test_back_to_back();
        test_reset_mid_drain();
        test_chain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
